circle_raster: RTL and testbench
================================

Name: circle_raster

Overview:
Parametrised, self-sequencing Bresenham circle rasteriser: owns its own FSM, octant sequencing and screen clipping, and streams clipped pixels to the VGA adapter through a ready/valid pixel port. Successor to the lab circle datapath, with the following generalisations:
- screen size, coordinate width and colour width are parameters;
- output accepts backpressure;
- optional filled-disc mode.
Sits between the top-level controller (start/done) and the VGA adapter.

Parameters:
SCREEN_W, 160, visible width in pixels; valid on-screen x is 0..SCREEN_W-1
SCREEN_H, 120, visible height in pixels; valid on-screen y is 0..SCREEN_H-1
X_DW, 8, width of vga_x; must hold SCREEN_W-1
Y_DW, 7, width of vga_y; must hold SCREEN_H-1
COORD_DW, 9, signed width of centre_x/centre_y; radius is COORD_DW-1 bits unsigned
COLOUR_DW, 3, pixel colour width

Ports:
clk  in  1  clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request a draw; level, sampled in IDLE only
centre_x  in  COORD_DW signed  circle centre x
centre_y  in  COORD_DW signed  circle centre y
radius  in  COORD_DW-1 unsigned  circle radius
colour  in  COLOUR_DW  pixel colour
fill  in  1  filled-disc request (used only with CIRCLE_FILL_EN)
busy  out  1  high from accept of start until DONE entered
done  out  1  draw complete
vga_x  out  X_DW  pixel x
vga_y  out  Y_DW  pixel y
vga_colour  out  COLOUR_DW  pixel colour
vga_plot  out  1  pixel valid
pix_ready  in  1  sink accepts pixel when vga_plot && pix_ready

Behaviour:
- Reset (async, resetn=0) forces state IDLE and all outputs to 0. Asserting reset mid-draw aborts the draw; no further pixels are emitted.
- IDLE, start=1:
  - latch centre_x, centre_y, radius, colour, fill;
  - set ox=radius, oy=0, crit=1-radius;
  - busy=1; go to OCT with oct=0.
- Start is ignored when the FSM is not in IDLE.
- OCT (oct 0..7) candidate points, in this order:
  - (cx+ox, cy+oy), (cx+oy, cy+ox), (cx-oy, cy+ox), (cx-ox, cy+oy);
  - (cx-ox, cy-oy), (cx-oy, cy-ox), (cx+oy, cy-ox), (cx+ox, cy-oy).
- Candidate arithmetic is signed, COORD_DW+1 bits, with no overflow.
- Clipping:
  - a candidate is on-screen iff 0<=x<=SCREEN_W-1 and 0<=y<=SCREEN_H-1;
  - on-screen: vga_plot=1, vga_x/vga_y = low bits of the candidate, vga_colour = latched colour;
  - advance oct only on the cycle where pix_ready=1;
  - vga_x/vga_y/vga_colour hold stable while stalled;
  - off-screen: vga_plot=0, vga_x=vga_y=0; advance next cycle regardless of pix_ready.
- After oct=7 is consumed, go to STEP (1 cycle, vga_plot=0):
  - oy<=oy+1;
  - if crit<=0: crit<=crit+2*(oy+1)+1;
  - else: ox<=ox-1 and crit<=crit+2*(oy+1-(ox-1))+1.
- crit is signed COORD_DW+2 bits.
- After STEP, if new oy<=new ox return to OCT with oct=0; else go to DONE.
- Duplicate pixels on octant boundaries are emitted as-is; they are not suppressed.
- radius=0 yields one iteration: 8 plots of the centre.
- DONE:
  - busy=0, done=1, vga_plot=0;
  - hold while start=1; go to IDLE when start=0 (done deasserts there).
  - start must drop for at least one cycle between draws.
- Latency with pix_ready held 1: exactly 9 cycles per iteration (8 OCT + 1 STEP), plus 1 cycle from start accept to first OCT.

Optional Feature:
CIRCLE_FILL_EN
- Defined, and latched fill=1:
  - each iteration emits up to 4 horizontal spans instead of 8 points:
    - x from cx-ox to cx+ox at rows cy+oy and cy-oy;
    - x from cx-oy to cx+oy at rows cy+ox and cy-ox.
  - Each span is clipped: start=max(lo,0), end=min(hi,SCREEN_W-1).
  - A span is skipped in 1 cycle if its row is off-screen or start>end.
  - Pixels are emitted left to right, one per accepted handshake.
  - STEP arithmetic is identical to outline mode.
- Defined, and latched fill=0: outline behaviour exactly as above.
- Not defined: fill port is present but ignored; span logic is not synthesised.

Test Plan:
1. r=0, centre (80,60), pix_ready=1 -> 8 plots all at (80,60); done 10 cycles after start accept; busy low in DONE.
2. r=1, centre (80,60) -> 16 plots: iteration 1 gives the set {(81,60),(80,61),(79,60),(80,59)}; iteration 2 gives the set {(81,61),(79,61),(79,59),(81,59)}; then done.
3. Clipping, centre (0,0), r=10 -> no plot with negative coordinate; every plotted pixel has x,y in 0..10; cycle count still equals 9 per iteration + 1.
4. Backpressure, r=5, pix_ready held 0 for 5 cycles mid-draw -> vga_x/vga_y/vga_plot unchanged during the stall; total accepted pixel sequence identical to the run with ready held 1.
5. Reset mid-draw: resetn=0 after the 3rd plot -> all outputs 0 immediately (async); after release, a new start draws a full circle correctly.
6. CIRCLE_FILL_EN, fill=1, r=2, centre (10,10) -> row 10 covers x 8..12; row 12 covers x 9..11; a centre with negative cx has its spans clipped at x=0; done asserted.

Source files
------------

// File: rtl/circle_raster.sv
// -----------------------------------------------------------------------------
// circle_raster
//   Self-sequencing Bresenham circle rasteriser. On start it latches the
//   centre, radius, colour and fill request. It walks the midpoint algorithm
//   one octant candidate per cycle, clips each candidate to the screen, and
//   streams on-screen pixels through a ready/valid port (vga_plot/pix_ready).
//   Duplicate pixels on octant boundaries are emitted as-is.
//
//   All outputs are registered. Each output register holds the decode of the
//   state that the FSM occupies during the same cycle, so the outputs track
//   the FSM without a pipeline offset.
//
// Optional feature macro: CIRCLE_FILL_EN
//   When defined and fill is latched high, each iteration emits four clipped
//   horizontal spans instead of eight points. When it is not defined, the
//   fill input is ignored and no span logic is built.
//
// Ports
//   clk, resetn        clock (rising edge), asynchronous active-low reset
//   start              draw request; level, sampled in IDLE only
//   centre_x/centre_y  signed circle centre, COORD_DW bits
//   radius             unsigned radius, COORD_DW-1 bits
//   colour             pixel colour
//   fill               filled-disc request (CIRCLE_FILL_EN builds only)
//   busy, done         draw in progress / draw complete
//   vga_x, vga_y       pixel coordinate (valid with vga_plot)
//   vga_colour         pixel colour (valid with vga_plot)
//   vga_plot           pixel valid
//   pix_ready          sink accepts the pixel when vga_plot && pix_ready
// -----------------------------------------------------------------------------
module circle_raster #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int X_DW      = 8,
  parameter int Y_DW      = 7,
  parameter int COORD_DW  = 9,
  parameter int COLOUR_DW = 3
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic signed [COORD_DW-1:0]  centre_x,
  input  logic signed [COORD_DW-1:0]  centre_y,
  input  logic        [COORD_DW-2:0]  radius,
  input  logic        [COLOUR_DW-1:0] colour,
  input  logic                        fill,
  output logic                        busy,
  output logic                        done,
  output logic        [X_DW-1:0]      vga_x,
  output logic        [Y_DW-1:0]      vga_y,
  output logic        [COLOUR_DW-1:0] vga_colour,
  output logic                        vga_plot,
  input  logic                        pix_ready
);

  // Candidate arithmetic is one bit wider than the centre so that cx +/- r
  // never overflows. The decision variable needs one more bit again.
  localparam int CW = COORD_DW + 1;
  localparam int KW = COORD_DW + 2;

  localparam logic signed [CW-1:0] ONE_C = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [KW-1:0] ONE_K = {{(KW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] X_MAX = CW'(SCREEN_W - 32'sd1);
  localparam logic signed [CW-1:0] Y_MAX = CW'(SCREEN_H - 32'sd1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OCT  = 2'd1,
    S_STEP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             oct_q, oct_d;
  logic signed [CW-1:0]   ox_q, ox_d, oy_q, oy_d;
  logic signed [KW-1:0]   crit_q, crit_d;
  logic signed [COORD_DW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [COLOUR_DW-1:0]   col_q, col_d;

  logic                   busy_q, busy_d, done_q, done_d, plot_q, plot_d;
  logic [X_DW-1:0]        x_q, x_d;
  logic [Y_DW-1:0]        y_q, y_d;
  logic [COLOUR_DW-1:0]   vcol_q, vcol_d;

  logic                   advance_s, enter_s, span_more_s, crit_pos_s;
  logic                   span_ok_s, on_screen_s;
  logic [2:0]             last_oct_s;
  logic signed [CW-1:0]   oy_step_s, ox_step_s, cx_e_s, cy_e_s;
  logic signed [CW-1:0]   cand_x_s, cand_y_s, pix_x_s, pix_y_s;
  logic signed [KW-1:0]   oy_k_s, ox_k_s, gap_s;

`ifdef CIRCLE_FILL_EN
  logic                   fill_q, fill_d, row_ok_s;
  logic signed [CW-1:0]   px_q, px_d, span_end_q, span_end_d;
  logic signed [CW-1:0]   row_s, lo_s, hi_s, sx_s, ex_s;
`endif

  // fill is only consumed by the span logic; enter_s likewise
  logic unused_s;
  assign unused_s = ^{fill, enter_s};

  // Next-state, Bresenham step and registered-output decode
  always_comb begin
    state_d = state_q;
    oct_d   = oct_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    crit_d  = crit_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    col_d   = col_q;
    enter_s = 1'b0;
`ifdef CIRCLE_FILL_EN
    fill_d      = fill_q;
    px_d        = px_q;
    span_end_d  = span_end_q;
    span_more_s = fill_q && plot_q && (px_q != span_end_q);
    last_oct_s  = fill_q ? 3'd3 : 3'd7;
`else
    span_more_s = 1'b0;
    last_oct_s  = 3'd7;
`endif

    // An off-screen slot never waits for the sink.
    advance_s  = ~plot_q | pix_ready;
    crit_pos_s = ~crit_q[KW-1] && (crit_q != '0);
    oy_step_s  = oy_q + ONE_C;
    ox_step_s  = crit_pos_s ? (ox_q - ONE_C) : ox_q;
    oy_k_s     = {oy_step_s[CW-1], oy_step_s};
    ox_k_s     = {ox_step_s[CW-1], ox_step_s};
    gap_s      = crit_pos_s ? (oy_k_s - ox_k_s) : oy_k_s;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cx_d    = centre_x;
          cy_d    = centre_y;
          col_d   = colour;
          ox_d    = {2'b00, radius};
          oy_d    = '0;
          crit_d  = ONE_K - {3'b000, radius};
          oct_d   = 3'd0;
          enter_s = 1'b1;
          state_d = S_OCT;
`ifdef CIRCLE_FILL_EN
          fill_d  = fill;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_OCT: begin
        if (!advance_s) begin
          state_d = S_OCT;
        end else if (span_more_s) begin
`ifdef CIRCLE_FILL_EN
          px_d = px_q + ONE_C;
`endif
        end else if (oct_q == last_oct_s) begin
          state_d = S_STEP;
        end else begin
          oct_d   = oct_q + 3'd1;
          enter_s = 1'b1;
        end
      end
      S_STEP: begin
        oy_d   = oy_step_s;
        ox_d   = ox_step_s;
        crit_d = crit_q + (gap_s <<< 1) + ONE_K;
        if (oy_step_s <= ox_step_s) begin
          oct_d   = 3'd0;
          enter_s = 1'b1;
          state_d = S_OCT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Candidate point for the slot the FSM moves into.
    cx_e_s = {cx_d[COORD_DW-1], cx_d};
    cy_e_s = {cy_d[COORD_DW-1], cy_d};
    case (oct_d)
      3'd0: begin cand_x_s = cx_e_s + ox_d; cand_y_s = cy_e_s + oy_d; end
      3'd1: begin cand_x_s = cx_e_s + oy_d; cand_y_s = cy_e_s + ox_d; end
      3'd2: begin cand_x_s = cx_e_s - oy_d; cand_y_s = cy_e_s + ox_d; end
      3'd3: begin cand_x_s = cx_e_s - ox_d; cand_y_s = cy_e_s + oy_d; end
      3'd4: begin cand_x_s = cx_e_s - ox_d; cand_y_s = cy_e_s - oy_d; end
      3'd5: begin cand_x_s = cx_e_s - oy_d; cand_y_s = cy_e_s - ox_d; end
      3'd6: begin cand_x_s = cx_e_s + oy_d; cand_y_s = cy_e_s - ox_d; end
      3'd7: begin cand_x_s = cx_e_s + ox_d; cand_y_s = cy_e_s - oy_d; end
      default: begin cand_x_s = cx_e_s; cand_y_s = cy_e_s; end
    endcase
    pix_x_s   = cand_x_s;
    pix_y_s   = cand_y_s;
    span_ok_s = 1'b1;

`ifdef CIRCLE_FILL_EN
    // Span k: rows cy+oy, cy-oy (half-width ox) then cy+ox, cy-ox (half-width oy).
    case (oct_d[1:0])
      2'd0: begin row_s = cy_e_s + oy_d; lo_s = cx_e_s - ox_d; hi_s = cx_e_s + ox_d; end
      2'd1: begin row_s = cy_e_s - oy_d; lo_s = cx_e_s - ox_d; hi_s = cx_e_s + ox_d; end
      2'd2: begin row_s = cy_e_s + ox_d; lo_s = cx_e_s - oy_d; hi_s = cx_e_s + oy_d; end
      2'd3: begin row_s = cy_e_s - ox_d; lo_s = cx_e_s - oy_d; hi_s = cx_e_s + oy_d; end
      default: begin row_s = cy_e_s; lo_s = cx_e_s; hi_s = cx_e_s; end
    endcase
    sx_s     = lo_s[CW-1] ? '0 : lo_s;
    ex_s     = (hi_s > X_MAX) ? X_MAX : hi_s;
    row_ok_s = ~row_s[CW-1] && (row_s <= Y_MAX);
    if (enter_s) begin
      px_d       = sx_s;
      span_end_d = ex_s;
    end else begin
      span_end_d = span_end_q;
    end
    // An empty span (start > end) shows up as plot=0 and is skipped in one cycle.
    if (fill_d) begin
      pix_x_s   = px_d;
      pix_y_s   = row_s;
      span_ok_s = row_ok_s && (px_d <= span_end_d);
    end else begin
      span_ok_s = 1'b1;
    end
`endif

    on_screen_s = span_ok_s
                && ~pix_x_s[CW-1] && (pix_x_s <= X_MAX)
                && ~pix_y_s[CW-1] && (pix_y_s <= Y_MAX);

    busy_d = (state_d == S_OCT) || (state_d == S_STEP);
    done_d = (state_d == S_DONE);
    if ((state_d == S_OCT) && on_screen_s) begin
      plot_d = 1'b1;
      x_d    = pix_x_s[X_DW-1:0];
      y_d    = pix_y_s[Y_DW-1:0];
      vcol_d = col_d;
    end else begin
      plot_d = 1'b0;
      x_d    = '0;
      y_d    = '0;
      vcol_d = '0;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      oct_q      <= 3'd0;
      ox_q       <= '0;
      oy_q       <= '0;
      crit_q     <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      col_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      plot_q     <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      vcol_q     <= '0;
`ifdef CIRCLE_FILL_EN
      fill_q     <= 1'b0;
      px_q       <= '0;
      span_end_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      oct_q      <= oct_d;
      ox_q       <= ox_d;
      oy_q       <= oy_d;
      crit_q     <= crit_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      col_q      <= col_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      plot_q     <= plot_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vcol_q     <= vcol_d;
`ifdef CIRCLE_FILL_EN
      fill_q     <= fill_d;
      px_q       <= px_d;
      span_end_q <= span_end_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_plot   = plot_q;
  assign vga_x      = x_q;
  assign vga_y      = y_q;
  assign vga_colour = vcol_q;

endmodule

// File: tb/tb_circle_raster.sv
// -----------------------------------------------------------------------------
// tb_circle_raster
//   Directed bench for circle_raster. Accepted pixels are collected per draw
//   and compared against hand-computed lists, or against a small integer
//   model of the midpoint algorithm with clipping.
// -----------------------------------------------------------------------------
module tb_circle_raster;

  localparam int COORD_DW  = 9;
  localparam int X_DW      = 8;
  localparam int Y_DW      = 7;
  localparam int COLOUR_DW = 3;

  logic                        clk = 1'b0;
  logic                        resetn;
  logic                        start;
  logic signed [COORD_DW-1:0]  centre_x;
  logic signed [COORD_DW-1:0]  centre_y;
  logic        [COORD_DW-2:0]  radius;
  logic        [COLOUR_DW-1:0] colour;
  logic                        fill;
  logic                        busy;
  logic                        done;
  logic        [X_DW-1:0]      vga_x;
  logic        [Y_DW-1:0]      vga_y;
  logic        [COLOUR_DW-1:0] vga_colour;
  logic                        vga_plot;
  logic                        pix_ready;

  circle_raster dut (
    .clk(clk), .resetn(resetn), .start(start),
    .centre_x(centre_x), .centre_y(centre_y), .radius(radius),
    .colour(colour), .fill(fill), .busy(busy), .done(done),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .pix_ready(pix_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int acc[$];
  int exp_q[$];
  int cyc;
  int col_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  function automatic int pk(input int x, input int y);
    return x * 128 + y;
  endfunction

  // Midpoint circle with on-screen filtering, straight from the algorithm.
  task automatic model_outline(input int cx, input int cy, input int r);
    int ox, oy, crit, x, y;
    exp_q.delete();
    ox = r; oy = 0; crit = 1 - r;
    while (oy <= ox) begin
      for (int o = 0; o < 8; o++) begin
        case (o)
          0: begin x = cx + ox; y = cy + oy; end
          1: begin x = cx + oy; y = cy + ox; end
          2: begin x = cx - oy; y = cy + ox; end
          3: begin x = cx - ox; y = cy + oy; end
          4: begin x = cx - ox; y = cy - oy; end
          5: begin x = cx - oy; y = cy - ox; end
          6: begin x = cx + oy; y = cy - ox; end
          default: begin x = cx + ox; y = cy - oy; end
        endcase
        if (x >= 0 && x < 160 && y >= 0 && y < 120) exp_q.push_back(pk(x, y));
      end
      oy++;
      if (crit <= 0) crit += 2 * oy + 1;
      else begin
        ox--;
        crit += 2 * (oy - ox) + 1;
      end
    end
  endtask

  task automatic add_span(input int row, input int lo, input int hi);
    int s, e;
    s = (lo < 0) ? 0 : lo;
    e = (hi > 159) ? 159 : hi;
    if (row >= 0 && row < 120)
      for (int x = s; x <= e; x++) exp_q.push_back(pk(x, row));
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_count"}, acc.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_px%0d", tag, i), (i < acc.size()) ? acc[i] : -1, exp_q[i]);
  endtask

  // One draw: start at a falling edge, then sample/drive on each falling edge.
  task automatic draw(input int cx, input int cy, input int r, input bit fl,
                      input bit hold, input int stall_at, input int stall_len);
    int k;
    logic [X_DW-1:0] hx;
    logic [Y_DW-1:0] hy;
    logic            hp;
    acc.delete();
    col_bad = 0;
    @(negedge clk);
    centre_x = cx[COORD_DW-1:0];
    centre_y = cy[COORD_DW-1:0];
    radius   = r[COORD_DW-2:0];
    fill     = fl;
    start    = 1'b1;
    pix_ready = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    k = 1;
    while (done !== 1'b1 && k < 3000) begin
      pix_ready = (k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1;
      if (k == stall_at) begin
        hx = vga_x; hy = vga_y; hp = vga_plot;
      end else if (k > stall_at && k < stall_at + stall_len) begin
        check("stall_x", vga_x, hx);
        check("stall_y", vga_y, hy);
        check("stall_plot", vga_plot, hp);
      end
      if (vga_plot && pix_ready) begin
        acc.push_back(pk(int'(vga_x), int'(vga_y)));
        if (vga_colour !== colour) col_bad++;
      end
      @(negedge clk);
      k++;
    end
    cyc = k;
    if (done !== 1'b1) check("done_timeout", 0, 1);
    check("busy_in_done", busy, 0);
    pix_ready = 1'b1;
    if (hold) begin
      @(negedge clk);
      check("done_hold", done, 1);
      start = 1'b0;
    end
    @(negedge clk);
    check("done_clear", done, 0);
  endtask

  initial begin
    int n, k;
    resetn = 1'b0; start = 1'b0; centre_x = '0; centre_y = '0; radius = '0;
    colour = 3'd5; fill = 1'b0; pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_plot", vga_plot, 0);
    check("rst_x", vga_x, 0);
    check("rst_y", vga_y, 0);
    check("rst_colour", vga_colour, 0);
    resetn = 1'b1;

    // r=0: eight plots of the centre, done 10 cycles after accept
    draw(80, 60, 0, 1'b0, 1'b0, -1, 0);
    check("t1_cycles", cyc, 10);
    check("t1_count", acc.size(), 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_px%0d", i), (i < acc.size()) ? acc[i] : -1, pk(80, 60));
    check("t1_colour", col_bad, 0);

    // r=1: two iterations with boundary duplicates, in slot order
    colour = 3'd2;
    exp_q = {pk(81,60), pk(80,61), pk(80,61), pk(79,60), pk(79,60), pk(80,59), pk(80,59), pk(81,60),
             pk(81,61), pk(81,61), pk(79,61), pk(79,61), pk(79,59), pk(79,59), pk(81,59), pk(81,59)};
    draw(80, 60, 1, 1'b0, 1'b0, -1, 0);
    check("t2_cycles", cyc, 19);
    compare_seq("t2");
    check("t2_colour", col_bad, 0);

    // start held through the draw: ignored while busy, DONE holds until it drops
    draw(80, 60, 0, 1'b0, 1'b1, -1, 0);
    check("hold_cycles", cyc, 10);
    check("hold_count", acc.size(), 8);

    // Clipping at the origin: 8 iterations, 18 survivors
    draw(0, 0, 10, 1'b0, 1'b0, -1, 0);
    check("t3_cycles", cyc, 73);
    check("t3_count", acc.size(), 18);
    n = 0;
    foreach (acc[i]) if ((acc[i] / 128) > 10 || (acc[i] % 128) > 10) n++;
    check("t3_range", n, 0);
    model_outline(0, 0, 10);
    compare_seq("t3");

    // Backpressure: same sequence with and without a 5-cycle stall
    model_outline(80, 60, 5);
    draw(80, 60, 5, 1'b0, 1'b0, -1, 0);
    check("t4_cycles", cyc, 37);
    compare_seq("t4a");
    draw(80, 60, 5, 1'b0, 1'b0, 12, 5);
    check("t4_stall_cycles", cyc, 42);
    compare_seq("t4b");

    // Reset after the third accepted pixel
    @(negedge clk);
    centre_x = 9'sd80; centre_y = 9'sd60; radius = 8'd5; start = 1'b1; pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; k = 0;
    while (n < 3 && k < 100) begin
      if (vga_plot && pix_ready) n++;
      if (n < 3) @(negedge clk);
      k++;
    end
    check("t5_reach", n, 3);
    @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_plot", vga_plot, 0);
    check("t5_x", vga_x, 0);
    check("t5_y", vga_y, 0);
    check("t5_colour", vga_colour, 0);
    repeat (3) @(negedge clk);
    check("t5_quiet", vga_plot, 0);
    resetn = 1'b1;
    exp_q = {pk(81,60), pk(80,61), pk(80,61), pk(79,60), pk(79,60), pk(80,59), pk(80,59), pk(81,60),
             pk(81,61), pk(81,61), pk(79,61), pk(79,61), pk(79,59), pk(79,59), pk(81,59), pk(81,59)};
    draw(80, 60, 1, 1'b0, 1'b0, -1, 0);
    check("t5_cycles", cyc, 19);
    compare_seq("t5");

`ifdef CIRCLE_FILL_EN
    // Filled disc r=2 at (10,10)
    exp_q.delete();
    add_span(10, 8, 12); add_span(10, 8, 12); add_span(12, 10, 10); add_span(8, 10, 10);
    add_span(11, 8, 12); add_span(9, 8, 12);  add_span(12, 9, 11);   add_span(8, 9, 11);
    draw(10, 10, 2, 1'b1, 1'b0, -1, 0);
    check("t6_cycles", cyc, 31);
    check("t6_total", acc.size(), 28);
    compare_seq("t6");
    // Negative centre x: spans clipped at x=0, empty spans skipped in one cycle
    exp_q.delete();
    add_span(10, -3, 1); add_span(10, -3, 1); add_span(12, -1, -1); add_span(8, -1, -1);
    add_span(11, -3, 1); add_span(9, -3, 1);  add_span(12, -2, 0);   add_span(8, -2, 0);
    draw(-1, 10, 2, 1'b1, 1'b0, -1, 0);
    check("t6n_cycles", cyc, 15);
    check("t6n_total", acc.size(), 10);
    compare_seq("t6n");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
